// File: rtl/pipelined_cla_adder_pkg.sv
// Shared adder definitions: default operand width and chunk size used by
// the pipelined carry-lookahead adder and its per-chunk logic.
package pipelined_cla_adder_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int ADDER_CHUNK = 4;

endpackage

// File: rtl/pipelined_cla_adder_chunk.sv
// cla_chunk: CHUNK-bit carry-lookahead slice. Every internal carry is a flat
// sum of generate/propagate products, so no carry ripples inside the chunk.
module cla_chunk
  import pipelined_cla_adder_pkg::*;
#(
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out,
  output logic             c_msb_in
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic             prod;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c_in
  always_comb begin
    c    = '0;
    prod = 1'b1;
    c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      prod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c[i+1] = c[i+1] | (g[j] & prod);
        prod   = prod & p[j];
      end
      c[i+1] = c[i+1] | (prod & c_in);
    end
  end

  assign s        = p ^ c[CHUNK-1:0];
  assign c_out    = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined add/subtract: stage k resolves bits [k*CHUNK +: CHUNK] while the
// unresolved operand bits travel alongside; valid/ready per stage lets bubbles collapse.
module pipelined_cla_adder
  import pipelined_cla_adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH,
  parameter int CHUNK = ADDER_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  logic [STAGES-1:0] v_p;
  logic [STAGES:0]   rdy;
  logic [WIDTH-1:0]  a_p   [STAGES];
  logic [WIDTH-1:0]  b_p   [STAGES];
  logic [WIDTH-1:0]  sum_p [STAGES];
  logic              c_p   [STAGES];

  logic [WIDTH-1:0]  b_in;
  logic              c_in0;

  // Subtraction is A + ~B + 1; cin is ignored in that mode.
  assign b_in  = sub ? ~b : b;
  assign c_in0 = sub | cin;

  assign rdy[STAGES] = out_ready;
  assign in_ready    = rdy[0];
  assign out_valid   = v_p[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic [WIDTH-1:0] sum_nxt;
    logic [CHUNK-1:0] s_chunk;
    logic             src_c;
    logic             src_v;
    logic             co;
    logic             cmi;
    logic             v_q;

    if (k == 0) begin : g_first
      assign src_a   = a;
      assign src_b   = b_in;
      assign src_sum = '0;
      assign src_c   = c_in0;
      assign src_v   = in_valid;
    end else begin : g_next
      assign src_a   = a_p[k-1];
      assign src_b   = b_p[k-1];
      assign src_sum = sum_p[k-1];
      assign src_c   = c_p[k-1];
      assign src_v   = v_p[k-1];
    end

    assign rdy[k] = !v_q || rdy[k+1];
    assign v_p[k] = v_q;

    cla_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a        (src_a[k*CHUNK +: CHUNK]),
      .b        (src_b[k*CHUNK +: CHUNK]),
      .c_in     (src_c),
      .s        (s_chunk),
      .c_out    (co),
      .c_msb_in (cmi)
    );

    always_comb begin
      sum_nxt                   = src_sum;
      sum_nxt[k*CHUNK +: CHUNK] = s_chunk;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) v_q <= 1'b0;
      else if (rdy[k]) v_q <= src_v;
    end

    if (k < STAGES - 1) begin : g_mid
      // ---- stage k -> k+1 boundary: skewed operands, partial sum, chunk carry ----
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] sum_q;
      logic             c_q;

      always_ff @(posedge clk) begin
        if (rdy[k] && src_v) begin
          a_q   <= src_a;
          b_q   <= src_b;
          sum_q <= sum_nxt;
          c_q   <= co;
        end
      end

      assign a_p[k]   = a_q;
      assign b_p[k]   = b_q;
      assign sum_p[k] = sum_q;
      assign c_p[k]   = c_q;
    end else begin : g_last
      // ---- output boundary: final sum, carry out of MSB, signed overflow ----
      logic [WIDTH-1:0] sum_q;
      logic             cout_q;
      logic             ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sum_q  <= '0;
          cout_q <= 1'b0;
          ovf_q  <= 1'b0;
        end else if (rdy[k] && src_v) begin
          sum_q  <= sum_nxt;
          cout_q <= co;
          ovf_q  <= cmi ^ co;
        end
      end

      assign a_p[k]   = src_a;
      assign b_p[k]   = src_b;
      assign sum_p[k] = sum_q;
      assign c_p[k]   = cout_q;
      assign sum      = sum_q;
      assign cout     = cout_q;
      assign ovf      = ovf_q;
    end
  end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed corner cases, back-to-back and
// backpressured random traffic against an arithmetic reference model.
module tb_pipelined_cla_adder;

  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int LAT = W / CH;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(W), .CHUNK(CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [W+1:0] exp;
    int           acc;
  } beat_t;

  beat_t        q[$];
  int           n_tests = 0;
  int           n_fail = 0;
  int           cyc = 0;
  bit           lat_check = 1'b0;
  int           pop_cnt = 0;
  int           first_pop = -1;
  int           last_pop = -1;
  bit           prev_hold = 1'b0;
  logic [W+1:0] prev_out = '0;
  bit           done = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {sum, cout, ovf}.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         co;
    logic         ov;
    if (!s) begin
      full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
      r    = full[W-1:0];
      co   = full[W];
      ov   = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      r  = x - y;
      co = (x >= y);
      ov = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end
    return {r, co, ov};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold)
        chk("hold", 64'({out_valid, sum, cout, ovf}), 64'({1'b1, prev_out}));
      if (in_valid && in_ready)
        q.push_back('{model(a, b, cin, sub), cyc});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_out", 64'(1), 64'(0));
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("result", 64'({sum, cout, ovf}), 64'(e.exp));
          if (lat_check) chk("latency", 64'(cyc - e.acc), 64'(LAT));
        end
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
        pop_cnt++;
      end
      prev_hold = out_valid && !out_ready;
      prev_out  = {sum, cout, ovf};
    end
  end

  task automatic scramble();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  task automatic push(input logic [W-1:0] pa, input logic [W-1:0] pb,
                      input logic pc, input logic ps);
    bit ok;
    ok = 1'b0;
    a = pa; b = pb; cin = pc; sub = ps;
    in_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("push_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("drain_empty", 64'(q.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic directed(input logic [W-1:0] pa, input logic [W-1:0] pb,
                          input logic pc, input logic ps,
                          input logic [W-1:0] es, input logic ec, input logic eo);
    out_ready = 1'b1;
    lat_check = 1'b1;
    push(pa, pb, pc, ps);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("dir_valid", 64'(out_valid), 64'(1));
    chk("dir_sum",   64'(sum),  64'(es));
    chk("dir_cout",  64'(cout), 64'(ec));
    chk("dir_ovf",   64'(ovf),  64'(eo));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_in_ready",  64'(in_ready),  64'(1));
    chk("rst_sum",       64'(sum),  64'(0));
    chk("rst_cout",      64'(cout), 64'(0));
    chk("rst_ovf",       64'(ovf),  64'(0));
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    directed(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);
    directed(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back random beats, one per cycle.
    out_ready = 1'b1;
    lat_check = 1'b1;
    pop_cnt = 0; first_pop = -1; last_pop = -1;
    for (int i = 0; i < 20; i++)
      push(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    drain();
    chk("b2b_count", 64'(pop_cnt), 64'(20));
    chk("b2b_span",  64'(last_pop - first_pop), 64'(19));

    // Fill under backpressure, then release.
    lat_check = 1'b0;
    out_ready = 1'b0;
    acc = 0;
    scramble();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!in_ready) break;
      acc++;
      @(posedge clk); #1;
      scramble();
    end
    chk("fill_count",    64'(acc), 64'(LAT));
    chk("in_ready_full", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      scramble();
    end
    chk("stall_valid", 64'(out_valid), 64'(1));
    pop_cnt = 0;
    out_ready = 1'b1;
    drain();
    chk("stall_drain_count", 64'(pop_cnt), 64'(LAT));

    // Random traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
            scramble();
          end
          push(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with beats in flight.
    for (int i = 0; i < 3; i++)
      push(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_in_ready",  64'(in_ready),  64'(1));
    chk("midrst_sum",       64'(sum),       64'(0));
    q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_valid", 64'(out_valid), 64'(0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_cla_adder.md
PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width; legal values are multiples of CHUNK, from 8 to 64.
REQ-002 SHALL have parameter CHUNK, default 4, bits resolved per pipeline stage.
REQ-003 SHALL derive STAGES = WIDTH/CHUNK as a localparam, not a port parameter.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, operand beat offered.
REQ-007 SHALL have port in_ready, output, 1, operand beat accepted this cycle.
REQ-008 SHALL have port a, input, WIDTH, operand A.
REQ-009 SHALL have port b, input, WIDTH, operand B.
REQ-010 SHALL have port cin, input, 1, carry-in; ignored when sub=1.
REQ-011 SHALL have port sub, input, 1, mode: 0 = A+B+cin, 1 = A-B.
REQ-012 SHALL have port out_valid, output, 1, result beat present.
REQ-013 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-014 SHALL have port sum, output, WIDTH, result.
REQ-015 SHALL have port cout, output, 1, carry out of the MSB.
REQ-016 SHALL have port ovf, output, 1, signed (two's-complement) overflow.

Function
REQ-017 SHALL transfer a beat when valid and ready are both high on the same edge, at input and at output.
REQ-018 SHALL, for sub=1, compute A + ~B + 1; cout=1 means no borrow.
REQ-019 SHALL resolve bits [k*CHUNK +: CHUNK] in stage k using carry-lookahead (generate/propagate) within the chunk.
REQ-020 SHALL register each stage's carry-out for stage k+1.
REQ-021 SHALL skew-register the unresolved operand bits alongside the data.
REQ-022 SHALL produce each result exactly STAGES cycles after acceptance when out_ready is held high.
REQ-023 SHALL sustain one beat per cycle when out_ready is held high.
REQ-024 SHALL give each stage k a valid bit v_k and a ready rdy_k = !v_k || rdy_{k+1}, with rdy_STAGES = out_ready and in_ready = rdy_0, so that bubbles collapse.
REQ-025 SHALL hold sum, cout, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-026 SHALL never drop or duplicate a beat under arbitrary out_ready backpressure.
REQ-027 SHALL keep result order equal to acceptance order.
REQ-028 SHALL compute ovf = carry into MSB XOR carry out of MSB.
REQ-029 SHALL let a, b, cin and sub change freely while in_valid=0 or in_ready=0 without affecting in-flight results.
REQ-030 SHALL, with the pipeline full and out_ready=0, drive in_ready=0.
REQ-031 SHALL, on a simultaneous output pop and input push, advance every stage in the same cycle.
REQ-032 SHALL have no combinational path from a/b to sum.
REQ-033 SHALL confine the only combinational path to out_ready -> in_ready, through the ready chain.

Reset
REQ-034 SHALL clear all v_k immediately on rst_n low, so out_valid=0 and in_ready=1 after reset.
REQ-035 SHALL reset sum, cout and ovf to 0.
REQ-036 SHALL discard in-flight beats on reset mid-operation; no result emerges after rst_n deasserts.
REQ-037 SHALL not rely on reset for data registers other than the output registers.

Structure
REQ-038 SHALL place the default WIDTH and CHUNK constants in the shared adder definitions include file used by the adder labs.
REQ-039 SHALL implement per-chunk logic in one sub-module, cla_chunk (CHUNK-bit CLA: a, b, c_in -> s, c_out, c_msb_in), instantiated STAGES times via generate.
REQ-040 SHALL keep pipeline valid/ready control in the top module only.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-041 SHALL verify: reset, then a=16'h00FF, b=16'h0001, cin=0, sub=0, out_ready=1 -> sum=16'h0100, cout=0, ovf=0, out_valid exactly 4 cycles after acceptance.
REQ-042 SHALL verify: a=16'h7FFF, b=16'h0001, sub=0 -> sum=16'h8000, ovf=1, cout=0; a=16'hFFFF, b=16'h0001, cin=1 -> sum=16'h0001, cout=1, ovf=0.
REQ-043 SHALL verify: sub=1, a=16'h0003, b=16'h0005 -> sum=16'hFFFE, cout=0; a=16'h8000, b=16'h0001 -> sum=16'h7FFF, ovf=1, cout=1.
REQ-044 SHALL verify: 20 back-to-back random beats with out_ready=1 -> 20 results in order, one per cycle, all matching a golden model.
REQ-045 SHALL verify: out_ready=0 while pushing -> in_ready falls after exactly 4 accepted beats, outputs hold stable; releasing out_ready drains 4 beats in order.
REQ-046 SHALL verify: assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately and stays 0 for 6 cycles after release with in_valid=0.
